// File: rtl/ternary_op_ctrl.sv
// Command sequencer for the ternary matrix-vector datapath: runs LOAD with a timeout,
// streams MULT vectors through in/wait/out phases, and honours ABORT from any state.
module ternary_op_ctrl #(
    parameter int MAX_IN_LEN   = 16,
    parameter int MAX_OUT_LEN  = 8,
    parameter int PIPE_LAT     = 1,
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [1:0]                     cmd_op,
    input  logic [6:0]                     cmd_arg,
    output logic                           load_ena,
    output logic [6:0]                     load_param,
    input  logic                           load_done,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic                           mult_en,
    output logic                           mult_first,
    output logic                           out_valid,
    output logic [$clog2(MAX_OUT_LEN)-1:0] out_idx,
    output logic [7:0]                     vec_cnt,
    output logic                           busy,
    output logic                           err
);
    localparam int PAIRS = MAX_IN_LEN / 2;
    localparam int PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int OW    = $clog2(MAX_OUT_LEN);
    localparam logic [PW-1:0] PAIR_LAST = PW'(PAIRS - 1);
    localparam logic [OW-1:0] OUT_LAST  = OW'(MAX_OUT_LEN - 1);
    localparam logic [7:0]    WAIT_LAST = (PIPE_LAT > 0) ? 8'(PIPE_LAT - 1) : 8'd0;
    localparam logic [7:0]    TO_LAST   = 8'(LOAD_TIMEOUT - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_IN, ST_WAIT, ST_OUT} state_t;

    state_t          state_r, state_s;
    logic [7:0]      to_cnt_r, wait_cnt_r, remaining_r, vec_cnt_r;
    logic [PW-1:0]   pair_cnt_r;
    logic [OW-1:0]   out_idx_r;
    logic [6:0]      load_param_r;
    logic            load_ena_r, in_ready_r, mult_en_r, out_valid_r, busy_r, err_r;
    logic            cmd_fire_s, abort_s, load_acc_s, mult_acc_s, pair_fire_s, last_byte_s, timeout_s;

    assign cmd_ready   = (state_r == ST_IDLE) | (cmd_op == 2'd3);
    assign cmd_fire_s  = cmd_valid & cmd_ready;
    assign abort_s     = cmd_fire_s & (cmd_op == 2'd3);
    assign load_acc_s  = cmd_fire_s & (state_r == ST_IDLE) & (cmd_op == 2'd1);
    assign mult_acc_s  = cmd_fire_s & (state_r == ST_IDLE) & (cmd_op == 2'd2);
    assign pair_fire_s = in_valid & in_ready_r;
    assign mult_first  = pair_fire_s & (pair_cnt_r == '0);
    assign last_byte_s = (state_r == ST_OUT) & (out_idx_r == OUT_LAST);
    // load_done beats a coincident timeout
    assign timeout_s   = (state_r == ST_LOAD) & ~load_done & (to_cnt_r == TO_LAST);

    assign load_ena   = load_ena_r;
    assign load_param = load_param_r;
    assign in_ready   = in_ready_r;
    assign mult_en    = mult_en_r;
    assign out_valid  = out_valid_r;
    assign out_idx    = out_idx_r;
    assign vec_cnt    = vec_cnt_r;
    assign busy       = busy_r;
    assign err        = err_r;

    // Next-state decode
    always_comb begin
        state_s = state_r;
        if (abort_s) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_acc_s)      state_s = ST_LOAD;
                    else if (mult_acc_s) state_s = ST_IN;
                    else                 state_s = ST_IDLE;
                end
                ST_LOAD: begin
                    if (load_done || timeout_s) state_s = ST_IDLE;
                    else                        state_s = ST_LOAD;
                end
                ST_IN: begin
                    if (pair_fire_s && (pair_cnt_r == PAIR_LAST))
                        state_s = (PIPE_LAT == 0) ? ST_OUT : ST_WAIT;
                    else
                        state_s = ST_IN;
                end
                ST_WAIT: begin
                    if (wait_cnt_r == WAIT_LAST) state_s = ST_OUT;
                    else                         state_s = ST_WAIT;
                end
                ST_OUT: begin
                    if (!last_byte_s)               state_s = ST_OUT;
                    else if (remaining_r == 8'd1)   state_s = ST_IDLE;
                    else                            state_s = ST_IN;
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // State register and registered phase outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            load_ena_r  <= 1'b0;
            in_ready_r  <= 1'b0;
            mult_en_r   <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            out_idx_r   <= '0;
        end else begin
            state_r     <= state_s;
            load_ena_r  <= (state_s == ST_LOAD);
            in_ready_r  <= (state_s == ST_IN);
            mult_en_r   <= (state_s == ST_IN) | (state_s == ST_WAIT) | (state_s == ST_OUT);
            out_valid_r <= (state_s == ST_OUT);
            busy_r      <= (state_s != ST_IDLE);
            if ((state_s == ST_OUT) && (state_r == ST_OUT)) out_idx_r <= out_idx_r + OW'(1);
            else                                            out_idx_r <= '0;
        end
    end

    // Command-scoped counters, load parameter and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r     <= 8'd0;
            wait_cnt_r   <= 8'd0;
            remaining_r  <= 8'd0;
            vec_cnt_r    <= 8'd0;
            pair_cnt_r   <= '0;
            load_param_r <= 7'h7F;
            err_r        <= 1'b0;
        end else begin
            if (load_acc_s)                 to_cnt_r <= 8'd0;
            else if (state_r == ST_LOAD)    to_cnt_r <= to_cnt_r + 8'd1;
            else                            to_cnt_r <= to_cnt_r;

            if (state_r == ST_WAIT) wait_cnt_r <= wait_cnt_r + 8'd1;
            else                    wait_cnt_r <= 8'd0;

            if (load_acc_s) load_param_r <= cmd_arg;
            else            load_param_r <= load_param_r;

            if (cmd_fire_s && (cmd_op != 2'd3)) err_r <= 1'b0;
            else if (timeout_s && !abort_s)     err_r <= 1'b1;
            else                                err_r <= err_r;

            // A MULT argument of zero requests the full 128 vectors
            if (mult_acc_s)       remaining_r <= (cmd_arg == 7'd0) ? 8'd128 : {1'b0, cmd_arg};
            else if (last_byte_s) remaining_r <= remaining_r - 8'd1;
            else                  remaining_r <= remaining_r;

            if (mult_acc_s)                             vec_cnt_r <= 8'd0;
            else if (last_byte_s && (vec_cnt_r != 8'hFF)) vec_cnt_r <= vec_cnt_r + 8'd1;
            else                                        vec_cnt_r <= vec_cnt_r;

            if (mult_acc_s)
                pair_cnt_r <= '0;
            else if ((state_r == ST_IN) && pair_fire_s)
                pair_cnt_r <= (pair_cnt_r == PAIR_LAST) ? '0 : pair_cnt_r + PW'(1);
            else
                pair_cnt_r <= pair_cnt_r;
        end
    end
endmodule

// File: tb/tb_ternary_op_ctrl.sv
// Directed bench for ternary_op_ctrl; output bytes and mult_first pulses are predicted
// into queues at command time and checked by a negedge monitor.
module tb_ternary_op_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [6:0] cmd_arg = 7'd0;
    logic       load_ena;
    logic [6:0] load_param;
    logic       load_done = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready, mult_en, mult_first, out_valid;
    logic [2:0] out_idx;
    logic [7:0] vec_cnt;
    logic       busy, err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pairs = 0;
    int last_pair_cyc = 0;

    typedef struct { int c; int idx; } out_exp_t;
    out_exp_t out_q[$];
    int       first_q[$];
    out_exp_t mon_e;
    int       mon_f;

    ternary_op_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .load_ena(load_ena), .load_param(load_param),
        .load_done(load_done), .in_valid(in_valid), .in_ready(in_ready), .mult_en(mult_en),
        .mult_first(mult_first), .out_valid(out_valid), .out_idx(out_idx), .vec_cnt(vec_cnt),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input int start);
        out_exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.c = start + i;
            e.idx = i;
            out_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        chk("idle_within_bound", {31'd0, busy}, 32'd0);
    endtask

    // Scoreboard monitor: pops predictions whenever the DUT emits a byte or first-pair pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                chk("out_expected", (out_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (out_q.size() > 0) begin
                    mon_e = out_q.pop_front();
                    chk("out_cycle", cyc, mon_e.c);
                    chk("out_idx", {29'd0, out_idx}, mon_e.idx);
                end
            end
            if (mult_first) begin
                chk("first_expected", (first_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (first_q.size() > 0) begin
                    mon_f = first_q.pop_front();
                    chk("first_cycle", cyc, mon_f);
                end
            end
            if (in_valid && in_ready) begin
                pairs++;
                last_pair_cyc = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int t, ena_cycles, n;

        // Reset values
        repeat (3) tick();
        chk("rst_load_param", load_param, 7'h7F);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_vec_cnt", vec_cnt, 0);
        rst_n = 1'b1;
        tick();

        // LOAD 0x15 with load_done five cycles after acceptance
        t = cyc;
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 7'h15;
        #1 chk("load_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("load_param_15", load_param, 7'h15);
        chk("load_busy", busy, 1);
        ena_cycles = 0;
        for (int k = 1; k <= 8; k++) begin
            load_done = (k == 5);
            if (load_ena) ena_cycles++;
            tick();
        end
        load_done = 1'b0;
        chk("load_ena_cycles", ena_cycles, 5);
        chk("load_err", err, 0);
        chk("load_done_busy", busy, 0);

        // LOAD timeout
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 7'h2A;
        tick();
        cmd_valid = 1'b0;
        n = 1;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        chk("timeout_latency", n, 256);
        chk("timeout_err", err, 1);
        chk("timeout_param", load_param, 7'h2A);
        cmd_valid = 1'b1; cmd_op = 2'd0;
        tick();
        cmd_valid = 1'b0;
        chk("nop_clears_err", err, 0);
        chk("nop_busy", busy, 0);

        // MULT of two vectors, in_valid always high
        t = cyc;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_arg = 7'd2; in_valid = 1'b1;
        push_vec(t + 10); push_vec(t + 27);
        first_q.push_back(t + 1); first_q.push_back(t + 18);
        tick();
        cmd_valid = 1'b0;
        chk("mult2_in_ready", in_ready, 1);
        wait_idle(100);
        chk("mult2_idle_cyc", cyc, t + 35);
        chk("mult2_vec_cnt", vec_cnt, 2);
        chk("mult2_q_empty", out_q.size() + first_q.size(), 0);
        in_valid = 1'b0;
        tick();

        // MULT of one vector with in_valid toggling
        t = cyc;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_arg = 7'd1;
        push_vec(t + 17);
        first_q.push_back(t + 1);
        pairs = 0;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (busy && n < 60) begin
            in_valid = ((cyc - t) % 2 == 1);
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("stall_pairs", pairs, 8);
        chk("stall_last_pair", last_pair_cyc, t + 15);
        chk("stall_idle_cyc", cyc, t + 25);
        chk("stall_vec_cnt", vec_cnt, 1);
        chk("stall_q_empty", out_q.size() + first_q.size(), 0);

        // MULT of 128 aborted after vector 3's 4th pair; LOAD while busy is refused
        t = cyc;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_arg = 7'd0; in_valid = 1'b1;
        for (int v = 0; v < 3; v++) push_vec(t + 10 + 17 * v);
        for (int v = 0; v < 4; v++) first_q.push_back(t + 1 + 17 * v);
        tick();
        cmd_valid = 1'b0;
        repeat (53) tick();
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 7'h33;
        #1 chk("busy_load_refused", cmd_ready, 0);
        tick();
        cmd_valid = 1'b0;
        chk("busy_still_mult", busy, 1);
        chk("busy_no_load_ena", load_ena, 0);
        tick();
        in_valid = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'd3;
        #1 chk("abort_ready", cmd_ready, 1);
        chk("abort_busy_before", busy, 1);
        tick();
        cmd_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_mult_en", mult_en, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_vec_cnt", vec_cnt, 3);
        chk("abort_param_held", load_param, 7'h2A);
        chk("abort_q_empty", out_q.size() + first_q.size(), 0);

        // ABORT on the final output byte still counts the vector
        t = cyc;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_arg = 7'd3; in_valid = 1'b1;
        push_vec(t + 10);
        first_q.push_back(t + 1);
        tick();
        cmd_valid = 1'b0;
        repeat (16) tick();
        cmd_valid = 1'b1; cmd_op = 2'd3;
        #1 chk("lastabort_out_valid", out_valid, 1);
        chk("lastabort_out_idx", out_idx, 7);
        tick();
        cmd_valid = 1'b0;
        chk("lastabort_busy", busy, 0);
        chk("lastabort_vec_cnt", vec_cnt, 1);
        tick();
        in_valid = 1'b0;
        chk("lastabort_q_empty", out_q.size() + first_q.size(), 0);

        // Asynchronous reset in the middle of OUT
        t = cyc;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_arg = 7'd1; in_valid = 1'b1;
        push_vec(t + 10);
        first_q.push_back(t + 1);
        tick();
        cmd_valid = 1'b0;
        repeat (11) tick();
        chk("pre_reset_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #2;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_mult_en", mult_en, 0);
        chk("arst_out_idx", out_idx, 0);
        chk("arst_load_param", load_param, 7'h7F);
        chk("arst_cmd_ready", cmd_ready, 1);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_q.delete();
        first_q.delete();
        tick();
        chk("post_reset_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
